// File: rtl/pito_mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM among NUM_PORTS requesters, with per-port read-valid return.
// Optional macro PITO_MEM_ARB_PRIO_EN gives port 0 (programming port) strict priority over the round-robin ports.
module pito_mem_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   be_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [DATA_W/8-1:0]             mem_be_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]               mem_wdata_o,
  input  logic [DATA_W-1:0]               mem_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [BE_W-1:0]   be_arr    [NUM_PORTS];
  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign be_arr[gi]    = be_i[gi*BE_W +: BE_W];
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             rd_load;

  always_comb begin : arb_search
    logic [PTR_W-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // ptr+i modulo NUM_PORTS without needing an extra carry bit
      if (ptr_reg >= PTR_W'(NUM_PORTS - i))
        idx = ptr_reg - PTR_W'(NUM_PORTS - i);
      else
        idx = ptr_reg + PTR_W'(i);
      if (!gnt_any && req_i[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef PITO_MEM_ARB_PRIO_EN
    if (req_i[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
`endif
    if (!rst_n)
      gnt_any = 1'b0;
  end

  always_comb begin
    gnt_o       = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    ptr_next    = ptr_reg;
    if (gnt_any) begin
      gnt_o[gnt_idx] = 1'b1;
      mem_we_o       = we_i[gnt_idx];
      mem_be_o       = be_arr[gnt_idx];
      mem_addr_o     = addr_arr[gnt_idx];
      mem_wdata_o    = wdata_arr[gnt_idx];
`ifdef PITO_MEM_ARB_PRIO_EN
      if (gnt_idx != '0)
`endif
        ptr_next = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign mem_req_o = gnt_any;
  assign rd_load   = gnt_any && !mem_we_o;
  assign rdata_o   = mem_rdata_i;

  // Read return pipeline: one {valid, port} entry per cycle of SRAM latency
  logic [RD_LATENCY-1:0] rd_valid_reg;
  logic [PTR_W-1:0]      rd_id_reg [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      rd_valid_reg <= '0;
      for (int s = 0; s < RD_LATENCY; s++)
        rd_id_reg[s] <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      rd_valid_reg[0] <= rd_load;
      rd_id_reg[0]    <= gnt_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        rd_valid_reg[s] <= rd_valid_reg[s-1];
        rd_id_reg[s]    <= rd_id_reg[s-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rd_valid_reg[RD_LATENCY-1])
      rvalid_o[rd_id_reg[RD_LATENCY-1]] = 1'b1;
  end

endmodule

// File: tb/tb_pito_mem_port_arbiter.sv
// Directed self-checking bench for pito_mem_port_arbiter (4 ports, 2-cycle SRAM model).
// Honours PITO_MEM_ARB_PRIO_EN for the arbitration-order steps.
module tb_pito_mem_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req;
  logic [NP-1:0]   we;
  logic [NP*4-1:0] be;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP-1:0]   gnt;
  logic [NP-1:0]   rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pito_mem_port_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural SRAM with 2-cycle read latency and byte-enabled writes
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (mem_req && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    rd_p0 <= sram[mem_addr];
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [3:0] b,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p]               = w;
    be[p*4 +: 4]        = b;
    addr[p*AW +: AW]    = a;
    wdata[p*DW +: DW]   = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111; we = '0; be = '0; addr = '0; wdata = '0;

    // Reset holds off all grants even with every port requesting
    cyc(); cyc(); #1;
    $display("reset: gnt=%b mem_req=%b rvalid=%b", gnt, mem_req, rvalid);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    rst_n = 1'b1; #1;
    $display("release: gnt=%b", gnt);
    chk("first_gnt", 32'(gnt), 32'h1);

`ifdef PITO_MEM_ARB_PRIO_EN
    cyc(); #1; chk("prio_gnt1", 32'(gnt), 32'h1);
    cyc(); #1; chk("prio_gnt2", 32'(gnt), 32'h1);
    cyc(); req = 4'b1110; #1; $display("prio drop0: gnt=%b", gnt); chk("prio_rr1", 32'(gnt), 32'h2);
    cyc(); #1; $display("prio: gnt=%b", gnt); chk("prio_rr2", 32'(gnt), 32'h4);
    cyc(); #1; $display("prio: gnt=%b", gnt); chk("prio_rr3", 32'(gnt), 32'h8);
`else
    cyc(); #1; $display("rr: gnt=%b", gnt); chk("rr_gnt1", 32'(gnt), 32'h2);
    cyc(); #1; $display("rr: gnt=%b", gnt); chk("rr_gnt2", 32'(gnt), 32'h4);
    cyc(); #1; $display("rr: gnt=%b", gnt); chk("rr_gnt3", 32'(gnt), 32'h8);
    cyc(); #1; $display("rr: gnt=%b", gnt); chk("rr_gnt4", 32'(gnt), 32'h1);
    cyc(); #1; $display("rr: gnt=%b", gnt); chk("rr_gnt5", 32'(gnt), 32'h2);
`endif

    // Idle: no grant, mem outputs zeroed; drain the read pipeline
    cyc(); req = '0; #1;
    $display("idle: gnt=%b mem_req=%b", gnt, mem_req);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_mem_req", 32'(mem_req), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    cyc(); cyc(); cyc(); #1;
    chk("drained_rvalid", 32'(rvalid), 32'h0);

    // Port 0 preloads 0x3A with DEADBEEF
    cyc(); req = 4'b0001; set_port(0, 1'b1, 4'hF, 10'h03A, 32'hDEADBEEF); #1;
    $display("wr p0: gnt=%b we=%b addr=%h wdata=%h be=%h", gnt, mem_we, mem_addr, mem_wdata, mem_be);
    chk("pre_gnt", 32'(gnt), 32'h1);
    chk("pre_we", 32'(mem_we), 32'h1);
    chk("pre_addr", 32'(mem_addr), 32'h3A);
    chk("pre_wdata", mem_wdata, 32'hDEADBEEF);
    chk("pre_be", 32'(mem_be), 32'hF);

    // Port 2 reads 0x3A: rvalid only two cycles later
    cyc(); req = 4'b0100; set_port(2, 1'b0, 4'hF, 10'h03A, 32'h0); #1;
    $display("rd p2: gnt=%b we=%b addr=%h rvalid=%b", gnt, mem_we, mem_addr, rvalid);
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_we", 32'(mem_we), 32'h0);
    chk("rd_addr", 32'(mem_addr), 32'h3A);
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    cyc(); req = '0; #1;
    chk("rd_t1_rvalid", 32'(rvalid), 32'h0);
    cyc(); #1;
    $display("rd p2 ret: rvalid=%b rdata=%h", rvalid, rdata);
    chk("rd_t2_rvalid", 32'(rvalid), 32'h4);
    chk("rd_t2_rdata", rdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("rd_t3_rvalid", 32'(rvalid), 32'h0);

    // Port 1 writes CAFEF00D at 0x10, port 3 reads it back next cycle
    cyc(); req = 4'b0010; set_port(1, 1'b1, 4'hF, 10'h010, 32'hCAFEF00D); #1;
    $display("wr p1: gnt=%b we=%b", gnt, mem_we);
    chk("wr1_gnt", 32'(gnt), 32'h2);
    chk("wr1_we", 32'(mem_we), 32'h1);
    cyc(); req = 4'b1000; set_port(3, 1'b0, 4'h0, 10'h010, 32'h0); #1;
    $display("rd p3: gnt=%b we=%b", gnt, mem_we);
    chk("rd3_gnt", 32'(gnt), 32'h8);
    chk("rd3_we", 32'(mem_we), 32'h0);
    cyc(); req = '0; #1;
    chk("rd3_t1_rvalid", 32'(rvalid), 32'h0);
    cyc(); #1;
    $display("rd p3 ret: rvalid=%b rdata=%h", rvalid, rdata);
    chk("rd3_t2_rvalid", 32'(rvalid), 32'h8);
    chk("rd3_t2_rdata", rdata, 32'hCAFEF00D);

    // be = 0 write is forwarded unchanged and returns nothing
    cyc(); req = 4'b0100; set_port(2, 1'b1, 4'h0, 10'h010, 32'h12345678); #1;
    $display("wr be0: gnt=%b we=%b be=%h wdata=%h", gnt, mem_we, mem_be, mem_wdata);
    chk("be0_we", 32'(mem_we), 32'h1);
    chk("be0_be", 32'(mem_be), 32'h0);
    chk("be0_wdata", mem_wdata, 32'h12345678);

    // Back-to-back reads on different ports return in grant order
    cyc(); req = 4'b0010; set_port(1, 1'b0, 4'hF, 10'h03A, 32'h0); #1;
    chk("b2b_gnt1", 32'(gnt), 32'h2);
    cyc(); req = 4'b0100; set_port(2, 1'b0, 4'hF, 10'h010, 32'h0); #1;
    chk("b2b_gnt2", 32'(gnt), 32'h4);
    cyc(); req = '0; #1;
    $display("b2b ret1: rvalid=%b rdata=%h", rvalid, rdata);
    chk("b2b_rvalid1", 32'(rvalid), 32'h2);
    chk("b2b_rdata1", rdata, 32'hDEADBEEF);
    cyc(); #1;
    $display("b2b ret2: rvalid=%b rdata=%h", rvalid, rdata);
    chk("b2b_rvalid2", 32'(rvalid), 32'h4);
    chk("b2b_rdata2", rdata, 32'hCAFEF00D);
    cyc(); #1;
    chk("b2b_rvalid3", 32'(rvalid), 32'h0);

    // Reset while two reads are in flight: neither may ever return
    cyc(); req = 4'b0001; set_port(0, 1'b0, 4'hF, 10'h03A, 32'h0); #1;
    chk("mid_gnt0", 32'(gnt), 32'h1);
    cyc(); req = 4'b0010; set_port(1, 1'b0, 4'hF, 10'h010, 32'h0); #1;
    chk("mid_gnt1", 32'(gnt), 32'h2);
    rst_n = 1'b0; #1;
    $display("mid reset: gnt=%b rvalid=%b", gnt, rvalid);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    cyc(); #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    req = '0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      $display("post reset cycle %0d: rvalid=%b", k, rvalid);
      chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    end

    // Pointer restarted at 0: ports 1..3 requesting -> port 1 first
    req = 4'b1110; #1;
    $display("post reset rr: gnt=%b", gnt);
    chk("post_rst_ptr", 32'(gnt), 32'h2);
    cyc(); req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pito_mem_port_arbiter.md
# pito_mem_port_arbiter

Parametrised N-port arbiter that multiplexes the instruction/data memory request channels of several requesters (pito harts plus the external programming port) onto one single-ported SRAM. It generalises the single-requester req/we/be/addr/wdata/rdata memory channel to NUM_PORTS channels with round-robin grant, a configurable read latency and per-port read-valid return. It sits between the core/SoC memory channels and the imem or dmem bank.

## Interface
Parameters:
- NUM_PORTS, 4: requester count, 1..16; port 0 is the external programming port.
- DATA_W, 32: data width, multiple of 8.
- ADDR_W, 10: word-address width.
- RD_LATENCY, 1: SRAM read latency in cycles, 1..4.

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS*DATA_W/8  per-port byte enables, port p at slice p.
- addr_i  in  NUM_PORTS*ADDR_W  per-port word address.
- wdata_i  in  NUM_PORTS*DATA_W  per-port write data.
- gnt_o  out  NUM_PORTS  one-hot grant, same cycle as accepted request.
- rvalid_o  out  NUM_PORTS  one-hot read-data valid.
- rdata_o  out  DATA_W  read data, shared by all ports.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_W/8  SRAM byte enables.
- mem_addr_o  out  ADDR_W  SRAM address.
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_rdata_i  in  DATA_W  SRAM read data, valid RD_LATENCY cycles after a read request.

## Operation
- Requester holds req_i[p] and its we/be/addr/wdata stable until gnt_o[p]; the transfer completes in the grant cycle. Dropping req before grant is allowed (withdrawal, no side effect).
- Grant is combinational: at most one gnt_o bit per cycle. No request -> gnt_o = 0, mem_req_o = 0.
- Round-robin: priority pointer ptr (log2 NUM_PORTS bits). Search order ptr, ptr+1, ... wrapping NUM_PORTS-1 -> 0; first requesting port wins. After a grant to port k, ptr <= (k+1) mod NUM_PORTS; no grant -> ptr unchanged.
- mem_* outputs are a combinational mux of the granted port's fields; with no grant, mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o drive 0.
- Read tracking: shift register of RD_LATENCY stages, each {valid, port id}. Stage 0 loads {1, k} on a granted read (we=0), {0, x} otherwise. Last stage drives rvalid_o one-hot; rdata_o = mem_rdata_i (pass-through).
- Writes produce no rvalid. be = 0 write is forwarded unchanged.
- Back-to-back reads (same or different ports) every cycle: full throughput, returns in grant order.
- NUM_PORTS = 1: gnt_o = req_i, ptr stays 0.

## Timing
- Reset (rst_n low, async): ptr = 0, all pipeline stages invalid, rvalid_o = 0, gnt_o = 0, mem_req_o = 0 regardless of req_i.
- Reset mid-operation: in-flight reads are discarded; no rvalid_o asserts after rst_n deasserts until a new read is granted.
- Grant at cycle t (read) -> rvalid_o[k] high for exactly one cycle at t+RD_LATENCY.
- A grant and an older read's rvalid in the same cycle are independent; a port may have up to RD_LATENCY reads outstanding.
- ptr update, pipeline shift on rising clk edge.

## Configuration
- PITO_MEM_ARB_PRIO_EN defined: port 0 has strict priority; whenever req_i[0] is high it is granted, and ptr is not updated on port-0 grants. Ports 1..NUM_PORTS-1 round-robin among themselves when port 0 is idle.
- Undefined: port 0 takes part in round-robin equally with all other ports.

## Test plan
Defaults NUM_PORTS=4, RD_LATENCY=2, macro undefined unless stated.
- Reset: rst_n=0 with req_i=4'b1111 -> gnt_o=0, mem_req_o=0, rvalid_o=0; release -> first grant to port 0.
- Round-robin: req_i=4'b1111 held 6 cycles -> gnt_o sequence 0001, 0010, 0100, 1000, 0001, 0010.
- Read latency: port 2 reads addr 0x3A at cycle t, SRAM returns 0xDEADBEEF -> rvalid_o=4'b0100 and rdata_o=0xDEADBEEF at t+2 only.
- Write then read: port 1 writes 0xCAFEF00D, be=4'hF, addr 0x10; port 3 reads 0x10 next cycle -> mem_we_o 1 then 0, rvalid_o=4'b1000 with 0xCAFEF00D two cycles after the read grant.
- Reset mid-read: grant reads on ports 0,1 in consecutive cycles, assert rst_n one cycle later -> no rvalid_o ever asserts for either.
- PITO_MEM_ARB_PRIO_EN defined: req_i=4'b1111 for 3 cycles -> gnt_o=0001 each cycle; drop req_i[0] -> 0010, 0100, 1000.
